// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared constants and FSM encoding for the instruction-memory loader
package instr_mem_loader_pkg;

    // Defaults shared with the debug unit and the UART receiver.
    localparam int IML_N_BITS    = 32;
    localparam int IML_BYTE_BITS = 8;
    localparam int IML_ADDR_BITS = 10;

    // End-of-program marker: written to memory, then the load stops.
    localparam logic [31:0] IML_HALT_WORD = 32'hFC000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_e;

    // A load is in progress while bytes are being collected or a word is being written.
    function automatic logic is_loading(input load_state_e s);
        return (s == ST_RECV) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - big-endian byte-to-word shift register with byte counter
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int N_BITS    = IML_N_BITS,
    parameter int BYTE_BITS = IML_BYTE_BITS
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_shift,
    input  logic [BYTE_BITS-1:0] i_byte,
    output logic [N_BITS-1:0]    o_word,
    output logic                 o_word_ready
);

    // Word width is a power-of-two multiple of the byte width, so the counter wraps to 0
    // by itself after the last byte of a word.
    localparam int BYTES_PER_WORD = N_BITS / BYTE_BITS;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [N_BITS-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Next-state: the first byte received ends up in the most significant byte lane.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (i_shift) begin
            word_d = {word_q[N_BITS-BYTE_BITS-1:0], i_byte};
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    // Shift register and byte counter; a clear drops any partial word.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_ready = i_shift && (idx_q == LAST_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - packs UART bytes into words and writes them to instruction memory
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int               N_BITS    = IML_N_BITS,
    parameter int               BYTE_BITS = IML_BYTE_BITS,
    parameter int               ADDR_BITS = IML_ADDR_BITS,
    parameter logic [N_BITS-1:0] HALT_WORD = IML_HALT_WORD
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [BYTE_BITS-1:0] i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_wr_en,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [N_BITS-1:0]    o_wr_data,
    output logic                 o_busy,
    output logic                 o_pc_hold,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [ADDR_BITS:0]   o_word_count
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

    load_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   count_q, count_d;

    logic                 pk_clear;
    logic                 pk_shift;
    logic [N_BITS-1:0]    pk_word;
    logic                 pk_word_ready;

    instr_mem_loader_byte_packer #(
        .N_BITS    (N_BITS),
        .BYTE_BITS (BYTE_BITS)
    ) u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (pk_clear),
        .i_shift      (pk_shift),
        .i_byte       (i_rx_data),
        .o_word       (pk_word),
        .o_word_ready (pk_word_ready)
    );

    // Load sequencing: collect bytes, write each full word, stop on HALT or a full memory.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // Received bytes are ignored here; only a start opens a new load.
                if (i_start) begin
                    state_d  = ST_RECV;
                    addr_d   = '0;
                    count_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_RECV: begin
                pk_shift = i_rx_valid;
                if (pk_word_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ADDR_BITS + 1)'(1);
                if (pk_word == HALT_WORD) begin
                    // HALT wins even when it lands in the last address.
                    state_d = ST_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_ERROR;
                end else begin
                    // A byte arriving now is the first byte of the next word.
                    state_d  = ST_RECV;
                    addr_d   = addr_q + ADDR_BITS'(1);
                    pk_shift = i_rx_valid;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, write address and word counter registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    // The strobe is masked by reset so a reset landing on a WRITE cycle never commits a word.
    assign o_wr_en      = (state_q == ST_WRITE) && !i_reset;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = pk_word;
    assign o_busy       = is_loading(state_q);
    assign o_pc_hold    = is_loading(state_q);
    assign o_done       = (state_q == ST_DONE);
    assign o_overflow   = (state_q == ST_ERROR);
    assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic        b_wr_en, b_busy, b_pc_hold, b_done, b_overflow;
    logic [9:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [10:0] b_count;

    logic        s_wr_en, s_busy, s_pc_hold, s_done, s_overflow;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] q_big[$];
    logic [63:0] q_small[$];

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_wr_en      (b_wr_en),
        .o_wr_addr    (b_wr_addr),
        .o_wr_data    (b_wr_data),
        .o_busy       (b_busy),
        .o_pc_hold    (b_pc_hold),
        .o_done       (b_done),
        .o_overflow   (b_overflow),
        .o_word_count (b_count)
    );

    instr_mem_loader #(.ADDR_BITS(2)) dut_small (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_wr_en      (s_wr_en),
        .o_wr_addr    (s_wr_addr),
        .o_wr_data    (s_wr_data),
        .o_busy       (s_busy),
        .o_pc_hold    (s_pc_hold),
        .o_done       (s_done),
        .o_overflow   (s_overflow),
        .o_word_count (s_count)
    );

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (b_wr_en) q_big.push_back({22'd0, b_wr_addr, b_wr_data});
        if (s_wr_en) q_small.push_back({30'd0, s_wr_addr, s_wr_data});
    end

    function automatic logic [63:0] ent(input logic [9:0] a, input logic [31:0] d);
        return {22'd0, a, d};
    endfunction

    function automatic logic [63:0] big_at(input int i);
        return (q_big.size() > i) ? q_big[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] small_at(input int i);
        return (q_small.size() > i) ? q_small[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q_big.delete();
        q_small.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Returns right after the 4th byte's edge, i.e. inside the WRITE cycle when loading.
    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[31:24]);
            v = v << 8;
            if (gap && i != 3) tick();
        end
    endtask

    initial begin
        // 1: reset and idle behaviour
        do_reset();
        expect_eq("rst_wr_en",    b_wr_en, 0);
        expect_eq("rst_wr_addr",  b_wr_addr, 0);
        expect_eq("rst_wr_data",  b_wr_data, 0);
        expect_eq("rst_busy",     b_busy, 0);
        expect_eq("rst_pc_hold",  b_pc_hold, 0);
        expect_eq("rst_done",     b_done, 0);
        expect_eq("rst_overflow", b_overflow, 0);
        expect_eq("rst_count",    b_count, 0);
        send_word(32'hFC000000, 0);
        tick();
        expect_eq("idle_no_write", q_big.size(), 0);
        expect_eq("idle_busy",     b_busy, 0);

        // 2: two words with gaps, HALT second
        pulse_start();
        expect_eq("t2_busy", b_busy, 1);
        send_word(32'h20010005, 1);
        expect_eq("t2_w0_en",   b_wr_en, 1);
        expect_eq("t2_w0_addr", b_wr_addr, 0);
        expect_eq("t2_w0_data", b_wr_data, 32'h20010005);
        tick();
        expect_eq("t2_between_en", b_wr_en, 0);
        send_word(32'hFC000000, 1);
        expect_eq("t2_w1_en",   b_wr_en, 1);
        expect_eq("t2_w1_addr", b_wr_addr, 1);
        expect_eq("t2_w1_data", b_wr_data, 32'hFC000000);
        expect_eq("t2_w1_hold", b_pc_hold, 1);
        tick();
        expect_eq("t2_hold_fall", b_pc_hold, 0);
        expect_eq("t2_done",      b_done, 1);
        expect_eq("t2_overflow",  b_overflow, 0);
        expect_eq("t2_count",     b_count, 2);
        expect_eq("t2_nwrites",   q_big.size(), 2);

        // 3: back-to-back bytes, including one during each WRITE
        do_reset();
        pulse_start();
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'hFC000000, 0);
        send_byte(8'hAB);
        tick();
        expect_eq("t3_nwrites", q_big.size(), 3);
        expect_eq("t3_w0", big_at(0), ent(10'd0, 32'h11223344));
        expect_eq("t3_w1", big_at(1), ent(10'd1, 32'h55667788));
        expect_eq("t3_w2", big_at(2), ent(10'd2, 32'hFC000000));
        expect_eq("t3_done",  b_done, 1);
        expect_eq("t3_count", b_count, 3);

        // 4: small memory fills without HALT, then with HALT in the last slot
        do_reset();
        pulse_start();
        send_word(32'h01020304, 0);
        send_word(32'h05060708, 0);
        send_word(32'h090A0B0C, 0);
        send_word(32'h0D0E0F10, 0);
        tick();
        send_word(32'hA0B0C0D0, 0);
        tick();
        expect_eq("t4_nwrites", q_small.size(), 4);
        expect_eq("t4_w0", small_at(0), ent(10'd0, 32'h01020304));
        expect_eq("t4_w1", small_at(1), ent(10'd1, 32'h05060708));
        expect_eq("t4_w2", small_at(2), ent(10'd2, 32'h090A0B0C));
        expect_eq("t4_w3", small_at(3), ent(10'd3, 32'h0D0E0F10));
        expect_eq("t4_overflow", s_overflow, 1);
        expect_eq("t4_done",     s_done, 0);
        expect_eq("t4_count",    s_count, 4);
        expect_eq("t4_busy",     s_busy, 0);
        q_small.delete();
        pulse_start();
        expect_eq("t4b_overflow_clr", s_overflow, 0);
        send_word(32'h01020304, 0);
        send_word(32'h05060708, 0);
        send_word(32'h090A0B0C, 0);
        send_word(32'hFC000000, 0);
        tick();
        expect_eq("t4b_nwrites",  q_small.size(), 4);
        expect_eq("t4b_w3",       small_at(3), ent(10'd3, 32'hFC000000));
        expect_eq("t4b_done",     s_done, 1);
        expect_eq("t4b_overflow", s_overflow, 0);
        expect_eq("t4b_count",    s_count, 4);

        // 5: reset in the middle of a word
        do_reset();
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        expect_eq("t5_nwrites", q_big.size(), 0);
        expect_eq("t5_busy",    b_busy, 0);
        expect_eq("t5_count",   b_count, 0);
        pulse_start();
        send_word(32'hFC000000, 0);
        tick();
        expect_eq("t5_nwrites2", q_big.size(), 1);
        expect_eq("t5_w0",       big_at(0), ent(10'd0, 32'hFC000000));
        expect_eq("t5_done",     b_done, 1);
        expect_eq("t5_count2",   b_count, 1);

        // 6: start ignored mid-load, honoured in DONE
        do_reset();
        pulse_start();
        send_word(32'hA1A2A3A4, 0);
        tick();
        pulse_start();
        send_word(32'hB1B2B3B4, 0);
        tick();
        send_word(32'hFC000000, 0);
        tick();
        expect_eq("t6_nwrites", q_big.size(), 3);
        expect_eq("t6_w0", big_at(0), ent(10'd0, 32'hA1A2A3A4));
        expect_eq("t6_w1", big_at(1), ent(10'd1, 32'hB1B2B3B4));
        expect_eq("t6_w2", big_at(2), ent(10'd2, 32'hFC000000));
        expect_eq("t6_done", b_done, 1);
        pulse_start();
        expect_eq("t6_done_clr", b_done, 0);
        expect_eq("t6_busy",     b_busy, 1);
        expect_eq("t6_count0",   b_count, 0);
        send_word(32'hC1C2C3C4, 0);
        expect_eq("t6_re_en",   b_wr_en, 1);
        expect_eq("t6_re_addr", b_wr_addr, 0);
        expect_eq("t6_re_data", b_wr_data, 32'hC1C2C3C4);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
